ex_stack_sequencer: RTL and testbench

EX-stage consumer of the 92-bit ID/EX pipeline word, owning the stack pointer and all stack memory traffic. Single-word stack ops (PUSH/POP of Data1) issue in one cycle. Multi-word ops (CALL, INT, RET, RTI) are sequenced over several cycles, with `stall` holding IF/ID and ID/EX. For RET/RTI it returns the popped PC and flags to the fetch and flag logic.

---
 rtl/ex_stack_sequencer_if.sv | 11 +
 rtl/ex_stack_sequencer.sv | 158 +++++++++++++++
 tb/tb_ex_stack_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_stack_sequencer_if.sv
// rtl/ex_stack_sequencer_if.sv - data memory port driven by the stack sequencer
interface ex_stack_sequencer_if;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/ex_stack_sequencer.sv
// rtl/ex_stack_sequencer.sv - EX-stage stack pointer owner and CALL/INT/RET/RTI sequencer
module ex_stack_sequencer #(
  parameter logic [31:0] SP_RESET = 32'h0000_07FF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [91:0]                 id_ex,
  input  logic [2:0]                  flags_in,
  ex_stack_sequencer_if.master        mem,
  output logic                        stall,
  output logic                        pc_load,
  output logic [31:0]                 pc_target,
  output logic                        flags_load,
  output logic [2:0]                  flags_out,
  output logic [31:0]                 sp
);

  typedef enum logic [3:0] {
    IDLE, PUSH1, POP1, PUSH_HI, PUSH_LO, PUSH_FL, POP_FL, POP_LO, POP_HI, POP_WB
  } state_t;

  state_t      state, state_next, cur;
  logic [31:0] sp_q, sp_next;
  logic        sp_load;
  logic        with_fl, with_fl_q;
  logic [15:0] lo_q;
  logic [2:0]  fl_q, flags_out_q;
  logic [31:0] pc_target_q;
  logic [31:0] fl_off;

  logic unused_bits;
  assign unused_bits = ^{id_ex[91], id_ex[88:84], id_ex[51:50], id_ex[47:25], id_ex[8:0]};

  // In IDLE the op is decoded straight from id_ex so the first cycle of any
  // sequence runs without a bubble; afterwards only the FSM state matters.
  always_comb begin
    with_fl = (state == IDLE) ? id_ex[90] : with_fl_q;
    cur     = state;
    if (!reset) begin
      cur = IDLE;
    end else if (state == IDLE) begin
      if (!id_ex[48])      cur = IDLE;
      else if (!id_ex[49]) cur = id_ex[89] ? PUSH_HI : PUSH1;
      else if (!id_ex[89]) cur = POP1;
      else                 cur = id_ex[90] ? POP_FL : POP_LO;
    end
  end

  always_comb begin
    fl_off        = {31'b0, with_fl};
    state_next    = IDLE;
    sp_next       = sp_q;
    sp_load       = 1'b0;
    stall         = 1'b0;
    pc_load       = 1'b0;
    flags_load    = 1'b0;
    mem.mem_addr  = 32'h0;
    mem.mem_wdata = 16'h0;
    mem.mem_we    = 1'b0;
    mem.mem_re    = 1'b0;
    case (cur)
      PUSH1: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp_q;
        mem.mem_wdata = id_ex[24:9];
        sp_next       = sp_q - 32'd1;
        sp_load       = 1'b1;
      end
      POP1: begin
        mem.mem_re   = 1'b1;
        mem.mem_addr = sp_q + 32'd1;
        sp_next      = sp_q + 32'd1;
        sp_load      = 1'b1;
      end
      PUSH_HI: begin
        stall         = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp_q;
        mem.mem_wdata = id_ex[83:68];
        state_next    = PUSH_LO;
      end
      PUSH_LO: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp_q - 32'd1;
        mem.mem_wdata = id_ex[67:52];
        if (with_fl) begin
          stall      = 1'b1;
          state_next = PUSH_FL;
        end else begin
          sp_next = sp_q - 32'd2;
          sp_load = 1'b1;
        end
      end
      PUSH_FL: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp_q - 32'd2;
        mem.mem_wdata = {13'b0, flags_in};
        sp_next       = sp_q - 32'd3;
        sp_load       = 1'b1;
      end
      POP_FL: begin
        stall        = 1'b1;
        mem.mem_re   = 1'b1;
        mem.mem_addr = sp_q + 32'd1;
        state_next   = POP_LO;
      end
      POP_LO: begin
        stall        = 1'b1;
        mem.mem_re   = 1'b1;
        mem.mem_addr = sp_q + 32'd1 + fl_off;
        state_next   = POP_HI;
      end
      POP_HI: begin
        stall        = 1'b1;
        mem.mem_re   = 1'b1;
        mem.mem_addr = sp_q + 32'd2 + fl_off;
        state_next   = POP_WB;
      end
      POP_WB: begin
        pc_load    = 1'b1;
        flags_load = with_fl;
        sp_next    = sp_q + 32'd2 + fl_off;
        sp_load    = 1'b1;
      end
      default: ;
    endcase
  end

  // Popped values are shown live during POP_WB, then held from the registers.
  always_comb begin
    pc_target = (cur == POP_WB) ? {mem.mem_rdata, lo_q} : pc_target_q;
    flags_out = (cur == POP_WB && with_fl) ? fl_q : flags_out_q;
    sp        = sp_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sp_q        <= SP_RESET;
      with_fl_q   <= 1'b0;
      lo_q        <= 16'h0;
      fl_q        <= 3'b0;
      pc_target_q <= 32'h0;
      flags_out_q <= 3'b0;
    end else begin
      state     <= state_next;
      with_fl_q <= with_fl;
      if (sp_load) sp_q <= sp_next;
      if (cur == POP_LO && with_fl) fl_q <= mem.mem_rdata[2:0];
      if (cur == POP_HI) lo_q <= mem.mem_rdata;
      if (cur == POP_WB) begin
        pc_target_q <= {mem.mem_rdata, lo_q};
        if (with_fl) flags_out_q <= fl_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_stack_sequencer.sv
// tb/tb_ex_stack_sequencer.sv - directed self-checking bench for ex_stack_sequencer
module tb_ex_stack_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [91:0] id_ex, id_ex2;
  logic [2:0]  flags_in;
  logic        stall, pc_load, flags_load;
  logic [31:0] pc_target, sp;
  logic [2:0]  flags_out;
  logic        stall2, pc_load2, flags_load2;
  logic [31:0] pc_target2, sp2;
  logic [2:0]  flags_out2;
  logic [15:0] tbmem [0:4095];
  int          n_cmp = 0;
  int          n_err = 0;

  ex_stack_sequencer_if bus();
  ex_stack_sequencer_if bus2();

  ex_stack_sequencer u_dut (
    .clk(clk), .reset(reset), .id_ex(id_ex), .flags_in(flags_in), .mem(bus.master),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
    .flags_load(flags_load), .flags_out(flags_out), .sp(sp)
  );

  ex_stack_sequencer #(.SP_RESET(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .id_ex(id_ex2), .flags_in(flags_in), .mem(bus2.master),
    .stall(stall2), .pc_load(pc_load2), .pc_target(pc_target2),
    .flags_load(flags_load2), .flags_out(flags_out2), .sp(sp2)
  );

  assign bus2.mem_rdata = 16'h0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) tbmem[i] = 16'h0;
    bus.mem_rdata = 16'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_we) tbmem[bus.mem_addr[11:0]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= tbmem[bus.mem_addr[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [91:0] mk(input bit s, input bit spop, input bit spc, input bit sfl,
                                     input logic [31:0] pc, input logic [15:0] d1);
    logic [91:0] w;
    w        = '0;
    w[48]    = s;
    w[49]    = spop;
    w[89]    = spc;
    w[90]    = sfl;
    w[83:52] = pc;
    w[24:9]  = d1;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_chk(input string tag, input logic we, input logic re,
                         input logic [31:0] addr, input logic [15:0] wd, input logic st);
    check({tag, ".we"}, {31'b0, bus.mem_we}, {31'b0, we});
    check({tag, ".re"}, {31'b0, bus.mem_re}, {31'b0, re});
    check({tag, ".addr"}, bus.mem_addr, addr);
    if (we) check({tag, ".wdata"}, {16'b0, bus.mem_wdata}, {16'b0, wd});
    check({tag, ".stall"}, {31'b0, stall}, {31'b0, st});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [91:0] idle_w;

  initial begin
    idle_w   = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'hFFFF) | (92'b11 << 44);
    id_ex    = idle_w;
    id_ex2   = '0;
    flags_in = 3'b000;
    @(negedge clk);
    #1;
    check("rst.sp", sp, 32'h7FF);
    bus_chk("rst", 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
    check("rst.pc_load", {31'b0, pc_load}, 32'h0);
    check("rst.flags_load", {31'b0, flags_load}, 32'h0);
    check("rst.pc_target", pc_target, 32'h0);
    check("rst.flags_out", {29'b0, flags_out}, 32'h0);
    check("rst.wdata", {16'b0, bus.mem_wdata}, 32'h0);
    step();
    reset = 1'b1;
    #1;
    bus_chk("idle", 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
    check("idle.sp", sp, 32'h7FF);

    // CALL PC=0x0001_2345
    id_ex = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0001_2345, 16'h1111);
    #1 bus_chk("call.c1", 1'b1, 1'b0, 32'h7FF, 16'h0001, 1'b1);
    check("call.c1.sp", sp, 32'h7FF);
    step(); #1;
    bus_chk("call.c2", 1'b1, 1'b0, 32'h7FE, 16'h2345, 1'b0);
    step();
    id_ex = idle_w;
    #1 check("call.sp", sp, 32'h7FD);
    bus_chk("call.after", 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
    check("call.mem7ff", {16'b0, tbmem[12'h7FF]}, 32'h0001);
    check("call.mem7fe", {16'b0, tbmem[12'h7FE]}, 32'h2345);

    // INT PC=0xABCD_0010 flags=101
    do_reset();
    flags_in = 3'b101;
    id_ex = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'hABCD_0010, 16'h2222);
    #1 bus_chk("int.c1", 1'b1, 1'b0, 32'h7FF, 16'hABCD, 1'b1);
    step(); #1;
    bus_chk("int.c2", 1'b1, 1'b0, 32'h7FE, 16'h0010, 1'b1);
    step(); #1;
    bus_chk("int.c3", 1'b1, 1'b0, 32'h7FD, 16'h0005, 1'b0);
    step();
    id_ex = idle_w;
    flags_in = 3'b010;
    #1 check("int.sp", sp, 32'h7FC);
    check("int.mem7fd", {16'b0, tbmem[12'h7FD]}, 32'h0005);

    // RTI from 0x7FC
    id_ex = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 16'h0);
    #1 bus_chk("rti.c1", 1'b0, 1'b1, 32'h7FD, 16'h0, 1'b1);
    step(); #1;
    bus_chk("rti.c2", 1'b0, 1'b1, 32'h7FE, 16'h0, 1'b1);
    step(); #1;
    bus_chk("rti.c3", 1'b0, 1'b1, 32'h7FF, 16'h0, 1'b1);
    check("rti.c3.pc_load", {31'b0, pc_load}, 32'h0);
    step(); #1;
    bus_chk("rti.c4", 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
    check("rti.pc_load", {31'b0, pc_load}, 32'h1);
    check("rti.flags_load", {31'b0, flags_load}, 32'h1);
    check("rti.pc_target", pc_target, 32'hABCD_0010);
    check("rti.flags_out", {29'b0, flags_out}, 32'h5);
    step();
    id_ex = idle_w;
    #1 check("rti.sp", sp, 32'h7FF);
    check("rti.pc_load_off", {31'b0, pc_load}, 32'h0);
    check("rti.pc_hold", pc_target, 32'hABCD_0010);
    check("rti.fl_hold", {29'b0, flags_out}, 32'h5);

    // PUSH 0xBEEF then POP back-to-back
    id_ex = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_5555, 16'hBEEF) | (92'b1 << 45);
    #1 bus_chk("push", 1'b1, 1'b0, 32'h7FF, 16'hBEEF, 1'b0);
    step();
    id_ex = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0) | (92'b1 << 44);
    #1 check("push.sp", sp, 32'h7FE);
    bus_chk("pop", 1'b0, 1'b1, 32'h7FF, 16'h0, 1'b0);
    step();
    id_ex = idle_w;
    #1 check("pop.sp", sp, 32'h7FF);
    check("pop.rdata", {16'b0, bus.mem_rdata}, 32'hBEEF);
    bus_chk("pop.after", 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);

    // CALL then RET restores PC, leaves flags untouched
    id_ex = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0001_2345, 16'h0);
    step(); step();
    id_ex = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0);
    #1 bus_chk("ret.c1", 1'b0, 1'b1, 32'h7FE, 16'h0, 1'b1);
    step(); #1;
    bus_chk("ret.c2", 1'b0, 1'b1, 32'h7FF, 16'h0, 1'b1);
    step(); #1;
    check("ret.pc_load", {31'b0, pc_load}, 32'h1);
    check("ret.flags_load", {31'b0, flags_load}, 32'h0);
    check("ret.pc_target", pc_target, 32'h0001_2345);
    check("ret.stall", {31'b0, stall}, 32'h0);
    step();
    id_ex = idle_w;
    #1 check("ret.sp", sp, 32'h7FF);
    check("ret.fl_hold", {29'b0, flags_out}, 32'h5);

    // Reset during POP_HI of RET
    id_ex = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 16'h0);
    #1 bus_chk("rrst.c1", 1'b0, 1'b1, 32'h800, 16'h0, 1'b1);
    step(); #1;
    bus_chk("rrst.c2", 1'b0, 1'b1, 32'h801, 16'h0, 1'b1);
    #1 reset = 1'b0;
    #1 check("rrst.sp_now", sp, 32'h7FF);
    check("rrst.stall_now", {31'b0, stall}, 32'h0);
    check("rrst.pc_load_now", {31'b0, pc_load}, 32'h0);
    id_ex = idle_w;
    step();
    reset = 1'b1;
    #1 bus_chk("rrst.idle", 1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
    check("rrst.pc_load", {31'b0, pc_load}, 32'h0);
    check("rrst.sp", sp, 32'h7FF);
    step(); #1;
    check("rrst.pc_load2", {31'b0, pc_load}, 32'h0);
    check("rrst.pc_target", pc_target, 32'h0);

    // SP wrap on the SP_RESET=0 instance
    check("wrap.sp0", sp2, 32'h0);
    id_ex2 = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h1234);
    #1 check("wrap.we", {31'b0, bus2.mem_we}, 32'h1);
    check("wrap.addr", bus2.mem_addr, 32'h0);
    step();
    id_ex2 = '0;
    #1 check("wrap.sp", sp2, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
